// File: rtl/gpu_pll_reset_sequencer.sv
// GPU PLL reset sequencer: holds the PLL in reset, waits for a debounced lock, then
// releases the GPU-domain reset. It retries on lock timeout, latches a fault, and re-sequences on lock loss.
module gpu_pll_reset_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    localparam int unsigned RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_locked,
    input  logic            soft_reset_req,
    output logic            pll_rst,
    output logic            gpu_rst_n,
    output logic            ready,
    output logic            fault,
    output logic [2:0]      state,
    output logic [RC_W-1:0] retry_count,
    output logic [7:0]      lock_loss_count
);

    localparam int unsigned MAX_A   = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES
                                                                              : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  retry_q, retry_d;
    logic [7:0]       llc_q, llc_d;
    logic             pll_rst_q, pll_rst_d;
    logic             gpu_rst_n_q, gpu_rst_n_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             lock_s;

    assign lock_s = sync_q[1];

    // One counter serves the hold, timeout and stability phases; each entry clears it.
    always_comb begin
        sync_d  = {sync_q[0], pll_locked};
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        llc_d   = llc_q;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_HOLD;
                        retry_d = retry_q + RC_W'(1);
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                cnt_d   = '0;
                retry_d = '0;
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase
        if (soft_reset_req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            retry_d = '0;
            llc_d   = llc_q;
        end
        pll_rst_d   = (state_d == ST_HOLD) || (state_d == ST_FAULT);
        gpu_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            llc_q       <= '0;
            pll_rst_q   <= 1'b1;
            gpu_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            llc_q       <= llc_d;
            pll_rst_q   <= pll_rst_d;
            gpu_rst_n_q <= gpu_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign gpu_rst_n       = gpu_rst_n_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign state           = state_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_gpu_pll_reset_sequencer.sv
// Directed bench for gpu_pll_reset_sequencer with small timing parameters.
module tb_gpu_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       gpu_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;
    int n;

    gpu_pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES        (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .gpu_rst_n      (gpu_rst_n),
        .ready          (ready),
        .fault          (fault),
        .state          (state),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_pll_rst(output int cnt);
        cnt = 0;
        while (pll_rst === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic count_wait_lock(output int cnt);
        cnt = 0;
        while (state === 3'd1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
        chk({tag, "_gpu_rst_n"}, 32'(gpu_rst_n), 0);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_retry"}, 32'(retry_count), 0);
        chk({tag, "_llc"}, 32'(lock_loss_count), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        pll_locked = 1'b0;
        soft_reset_req = 1'b0;
        repeat (3) tick();
        chk_reset_values("rst");

        // Nominal bring-up
        rst_n = 1'b1;
        count_pll_rst(n);
        chk("nom_hold_len", 32'(n), 4);
        chk("nom_wait_state", 32'(state), 1);
        repeat (9) tick();
        pll_locked = 1'b1;
        tick(); tick();
        chk("nom_sync_still_wait", 32'(state), 1);
        tick();
        chk("nom_stable", 32'(state), 2);
        repeat (7) tick();
        chk("nom_stable_end", 32'(state), 2);
        chk("nom_gpu_held", 32'(gpu_rst_n), 0);
        tick();
        chk("nom_run", 32'(state), 3);
        chk("nom_ready", 32'(ready), 1);
        chk("nom_gpu_rel", 32'(gpu_rst_n), 1);
        chk("nom_pll_rst", 32'(pll_rst), 0);
        chk("nom_retry", 32'(retry_count), 0);

        // Lock loss while running
        pll_locked = 1'b0;
        tick(); tick();
        chk("loss_ready_before", 32'(ready), 1);
        tick();
        chk("loss_ready", 32'(ready), 0);
        chk("loss_gpu", 32'(gpu_rst_n), 0);
        chk("loss_state", 32'(state), 0);
        chk("loss_llc", 32'(lock_loss_count), 1);
        chk("loss_pll_rst", 32'(pll_rst), 1);
        repeat (4) tick();
        chk("loss_rewait", 32'(state), 1);

        // Lock chatter during STABLE
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        chk("chat_stable", 32'(state), 2);
        tick();
        chk("chat_back_wait", 32'(state), 1);
        chk("chat_retry", 32'(retry_count), 0);
        tick();
        chk("chat_restable", 32'(state), 2);
        repeat (7) tick();
        chk("chat_not_run", 32'(state), 2);
        tick();
        chk("chat_run", 32'(state), 3);
        chk("chat_ready", 32'(ready), 1);

        // Soft reset on the cycle the lock loss is acted on
        pll_locked = 1'b0;
        tick(); tick();
        chk("sr_still_run", 32'(ready), 1);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("sr_state", 32'(state), 0);
        chk("sr_llc", 32'(lock_loss_count), 1);
        chk("sr_gpu", 32'(gpu_rst_n), 0);

        // Asynchronous reset in the middle of STABLE
        pll_locked = 1'b1;
        repeat (5) tick();
        chk("ar_stable", 32'(state), 2);
        repeat (2) tick();
        #1 rst_n = 1'b0;
        #1 chk_reset_values("ar");
        tick();
        rst_n = 1'b1;
        count_pll_rst(n);
        chk("ar_hold_len", 32'(n), 4);
        chk("ar_wait", 32'(state), 1);
        tick();
        chk("ar_stable2", 32'(state), 2);
        repeat (8) tick();
        chk("ar_run", 32'(state), 3);

        // Lock timeouts, retries and latched fault
        pll_locked = 1'b0;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("to_start_state", 32'(state), 0);
        chk("to_start_llc", 32'(lock_loss_count), 0);
        for (int i = 0; i < 3; i++) begin
            count_pll_rst(n);
            chk("to_hold_len", 32'(n), 4);
            count_wait_lock(n);
            chk("to_wait_len", 32'(n), 32);
            if (i < 2) begin
                chk("to_retry_state", 32'(state), 0);
                chk("to_retry_count", 32'(retry_count), 32'(i + 1));
            end else begin
                chk("to_fault_state", 32'(state), 4);
                chk("to_fault_flag", 32'(fault), 1);
                chk("to_fault_pll_rst", 32'(pll_rst), 1);
                chk("to_fault_gpu", 32'(gpu_rst_n), 0);
                chk("to_fault_retry", 32'(retry_count), 2);
            end
        end
        repeat (5) tick();
        chk("fault_latched", 32'(state), 4);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("fault_exit_state", 32'(state), 0);
        chk("fault_exit_flag", 32'(fault), 0);
        chk("fault_exit_retry", 32'(retry_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
